// File: rtl/bram_arbiter_if.sv
// Requester-side bundle for bram_arbiter: request handshake plus shared read-response return.
interface bram_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 14,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NREQ engines, with a zero-fill clear sequencer.
// Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module bram_arbiter #(
  parameter int NREQ  = 3,
  parameter int AW    = 14,
  parameter int DW    = 32,
  parameter int DEPTH = 10001
) (
  input  logic          clk,
  input  logic          rst,
  bram_arbiter_if.slave bus,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          bram_en,
  output logic [3:0]    bram_wen,
  output logic [31:0]   bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ARB, CLEAR} state_e;

  state_e                   state_q;
  logic [CW-1:0]            clr_addr_q;
  logic [NREQ-1:0]          rsp_valid_q;
  logic                     clr_done_q;

  logic [NREQ-1:0][AW-1:0]  addr_a;
  logic [NREQ-1:0][DW-1:0]  wdata_a;
  logic [PW-1:0]            gnt_idx;
  logic                     gnt_any;
  logic                     grant_en;
  logic                     gnt_we;
  logic [NREQ-1:0]          gnt_oh;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*AW +: AW];
    assign wdata_a[g] = bus.req_wdata[g*DW +: DW];
  end

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest valid index is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr_q;

  // Scan offsets from far to near so the candidate closest to rr_ptr wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end
`endif

  assign grant_en = gnt_any && (state_q == ARB) && !clr_start && !rst;
  assign gnt_we   = bus.req_we[gnt_idx];

  always_comb begin
    gnt_oh = '0;
    if (grant_en) gnt_oh[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = bram_dout;
  assign clr_busy      = (state_q == CLEAR);
  assign clr_done      = clr_done_q;

  always_comb begin
    bram_en   = 1'b0;
    bram_wen  = 4'b0000;
    bram_addr = '0;
    bram_din  = '0;
    if (!rst) begin
      if (state_q == CLEAR) begin
        bram_en   = 1'b1;
        bram_wen  = 4'b1111;
        bram_addr = 32'(clr_addr_q);
      end else if (grant_en) begin
        bram_en   = 1'b1;
        bram_wen  = {4{gnt_we}};
        bram_addr = 32'(addr_a[gnt_idx]);
        bram_din  = wdata_a[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      clr_addr_q  <= '0;
      rsp_valid_q <= '0;
      clr_done_q  <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      clr_done_q  <= 1'b0;
      // BRAM read latency is one cycle, so the response tags the grant just issued.
      rsp_valid_q <= (grant_en && !gnt_we) ? gnt_oh : '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      if (grant_en)
        rr_ptr_q <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
`endif
      case (state_q)
        ARB: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr_q == CW'(DEPTH - 1)) begin
            state_q    <= ARB;
            clr_addr_q <= '0;
            clr_done_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + CW'(1);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a BRAM model and a read-response scoreboard.
module tb_bram_arbiter;
  localparam int NREQ = 3, AW = 14, DW = 32, DEPTH = 16;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  localparam int RR_SEQ [6] = '{0, 0, 0, 0, 0, 0};
  localparam int SKIP_G     = 0;
  localparam int G110 [2]   = '{1, 1};
  localparam int RESUME_G   = 0;
`else
  localparam int RR_SEQ [6] = '{0, 1, 2, 0, 1, 2};
  localparam int SKIP_G     = 2;
  localparam int G110 [2]   = '{1, 2};
  localparam int RESUME_G   = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start, clr_busy, clr_done, bram_en;
  logic [3:0]    bram_wen;
  logic [31:0]   bram_addr;
  logic [DW-1:0] bram_din, bram_dout;

  always #5 clk = ~clk;

  bram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  bram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_wen == 4'hF) mem[bram_addr[7:0]] <= bram_din;
      bram_dout <= mem[bram_addr[7:0]];
    end
  end

  typedef struct { int idx; logic [31:0] data; int cyc; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          checks = 0, failures = 0, cyc_n = 0;
  logic [NREQ-1:0] cur_we;
  logic [AW-1:0]   cur_a;
  logic [DW-1:0]   cur_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    logic [NREQ-1:0] oh;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n - 1) begin
      e  = exp_q.pop_front();
      oh = '0;
      oh[e.idx] = 1'b1;
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
    end else begin
      chk("rsp_idle", 64'(bus.rsp_valid), 64'(0));
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic cs);
    @(negedge clk);
    cyc_n++;
    check_rsp();
    bus.req_valid = v;
    bus.req_we    = we;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW]  = v[i] ? a : 14'h3ABC;
      bus.req_wdata[i*DW +: DW] = v[i] ? d : 32'hBAD0_0000;
    end
    clr_start = cs;
    cur_we = we; cur_a = a; cur_d = d;
    #1;
  endtask

  task automatic expect_gnt(input string tag, input int g);
    logic [NREQ-1:0] oh;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(oh));
    chk({tag, "_en"}, 64'(bram_en), 64'(g >= 0));
    if (g >= 0) begin
      chk({tag, "_wen"}, 64'(bram_wen), cur_we[g] ? 64'hF : 64'h0);
      chk({tag, "_addr"}, 64'(bram_addr), 64'(cur_a));
      if (cur_we[g]) begin
        chk({tag, "_din"}, 64'(bram_din), 64'(cur_d));
        ref_mem[cur_a[7:0]] = cur_d;
      end else begin
        exp_q.push_back('{idx: g, data: ref_mem[cur_a[7:0]], cyc: cyc_n});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    bus.req_valid = '1; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_en", 64'(bram_en), 64'(0));
    chk("rst_wen", 64'(bram_wen), 64'(0));
    chk("rst_busy", 64'(clr_busy), 64'(0));
    chk("rst_done", 64'(clr_done), 64'(0));
    chk("rst_rsp", 64'(bus.rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0; bus.req_valid = '0;

    step(3'b001, 3'b001, 14'd5, 32'hDEADBEEF, 1'b0); expect_gnt("wr5", 0);
    step(3'b010, 3'b000, 14'd5, 32'h0, 1'b0);        expect_gnt("rd5", 1);
    step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0);        expect_gnt("idle", -1);
    step(3'b001, 3'b001, 14'd100, 32'h12345678, 1'b0); expect_gnt("wr100", 0);
    step(3'b100, 3'b000, 14'd100, 32'h0, 1'b0);      expect_gnt("rd100", 2);

    for (int i = 0; i < 6; i++) begin
      step(3'b111, 3'b000, 14'd5, 32'h0, 1'b0); expect_gnt("rr", RR_SEQ[i]);
    end
    step(3'b111, 3'b000, 14'd5, 32'h0, 1'b0); expect_gnt("rr_a", 0);
    step(3'b101, 3'b000, 14'd5, 32'h0, 1'b0); expect_gnt("rr_skip", SKIP_G);
    for (int i = 0; i < 2; i++) begin
      step(3'b110, 3'b000, 14'd5, 32'h0, 1'b0); expect_gnt("g110", G110[i]);
    end

    // clear under full contention
    step(3'b111, 3'b000, 14'd5, 32'h0, 1'b0); expect_gnt("pre_clr", 0);
    step(3'b111, 3'b000, 14'd5, 32'h0, 1'b1); expect_gnt("clr_start", -1);
    chk("clr_start_busy", 64'(clr_busy), 64'(0));
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      step(3'b111, 3'b000, 14'd5, 32'h0, k == 4);
      chk("clr_ready", 64'(bus.req_ready), 64'(0));
      chk("clr_en", 64'(bram_en), 64'(1));
      chk("clr_wen", 64'(bram_wen), 64'hF);
      chk("clr_addr", 64'(bram_addr), 64'(k));
      chk("clr_din", 64'(bram_din), 64'(0));
      chk("clr_busy", 64'(clr_busy), 64'(1));
      chk("clr_done_early", 64'(clr_done), 64'(0));
    end
    step(3'b111, 3'b000, 14'd0, 32'h0, 1'b0);
    chk("clr_done", 64'(clr_done), 64'(1));
    chk("clr_busy_end", 64'(clr_busy), 64'(0));
    expect_gnt("resume", RESUME_G);
    step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0); expect_gnt("post_clr", -1);
    chk("clr_done_once", 64'(clr_done), 64'(0));
    for (int k = 0; k < DEPTH; k++) begin
      step(3'b001, 3'b000, AW'(k), 32'h0, 1'b0); expect_gnt("rd_clr", 0);
    end
    step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0); expect_gnt("flush", -1);

    // reset in the middle of a clear
    step(3'b000, 3'b000, 14'd0, 32'h0, 1'b1); expect_gnt("clr2_start", -1);
    for (int k = 0; k < 7; k++) begin
      step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0);
      chk("clr2_addr", 64'(bram_addr), 64'(k));
    end
    step(3'b111, 3'b000, 14'd5, 32'h0, 1'b0);
    chk("clr2_addr7", 64'(bram_addr), 64'(7));
    rst = 1'b1;
    #1;
    chk("abort_en", 64'(bram_en), 64'(0));
    chk("abort_busy", 64'(clr_busy), 64'(0));
    chk("abort_ready", 64'(bus.req_ready), 64'(0));
    step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0);
      chk("abort_no_done", 64'(clr_done), 64'(0));
      chk("abort_idle_en", 64'(bram_en), 64'(0));
    end
    step(3'b111, 3'b000, 14'd100, 32'h0, 1'b0); expect_gnt("post_rst", 0);
    step(3'b000, 3'b000, 14'd0, 32'h0, 1'b0);   expect_gnt("final", -1);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port 32-bit weight/feature-map BRAM (registered read, 1-cycle latency, word-addressed, full-word write strobe) among NREQ LeNet-5 engines (e.g. host loader, conv, pool/FC).
- Round-robin arbitration with a valid/ready request handshake and a fixed-latency read-response return.
- Built-in clear sequencer zero-fills the whole memory between inferences.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 14, requester address width, word address.
- DW, 32, data width; must match BRAM.
- DEPTH, 10001, words swept by clear (addresses 0..DEPTH-1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_ready  out  NREQ  grant; a transfer occurs when valid&ready.
- rsp_valid  out  NREQ  read data valid for requester i.
- rsp_rdata  out  DW  read data, shared by all requesters.
- clr_start  in  1  pulse: begin memory clear.
- clr_busy  out  1  high while clearing.
- clr_done  out  1  one-cycle completion pulse.
- bram_en  out  1  to BRAM en.
- bram_wen  out  4  to BRAM wen; 4'b1111 or 4'b0000 only.
- bram_addr  out  32  to BRAM addr; zero-extended.
- bram_din  out  DW  to BRAM din.
- bram_dout  in  DW  from BRAM dout.

Behaviour:
- States: ARB, CLEAR. Reset → ARB, rr_ptr=0, clr_addr=0, rsp_valid=0, clr_busy=0, clr_done=0.
- While rst is high: req_ready=0, bram_en=0, bram_wen=0.
- ARB grant:
  - Grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready is combinational: exactly one bit high, the granted one; never high without its valid.
  - Granted cycle drives bram_en=1, bram_wen = req_we ? 1111 : 0000, bram_addr = zero-extended req_addr, bram_din = req_wdata.
  - rr_ptr <= grant+1, wrapping NREQ-1 → 0.
  - No valid: bram_en=0, bram_wen=0, rr_ptr held.
- Read response:
  - A read granted at cycle T gives rsp_valid[grant]=1 at T+1 only.
  - rsp_rdata = bram_dout, a direct wire.
  - Writes produce no rsp_valid. The BRAM may update dout on a write; this is ignored.
  - There is no response backpressure; requesters must accept.
  - Back-to-back reads give one response per cycle, in grant order.
- Request stability: a requester holds addr/we/wdata stable while valid&&!ready.
- Clear:
  - clr_start high in ARB → no grant that cycle (req_ready=0, bram_en=0); next state CLEAR with clr_addr=0.
  - A response owed from the previous cycle is still delivered.
  - In CLEAR, each cycle: bram_en=1, wen=1111, addr=clr_addr, din=0, clr_addr++. req_ready=0, clr_busy=1.
  - After the write at clr_addr=DEPTH-1: return to ARB, clr_addr=0, clr_done=1 for exactly one cycle (the first ARB cycle). Arbitration resumes in that same cycle.
  - The clear takes exactly DEPTH write cycles.
  - clr_start during CLEAR is ignored. rr_ptr is unchanged by a clear.
- Reset asserted mid-clear aborts immediately: no clr_done, state ARB, memory partially cleared.
- req_addr ≥ DEPTH is passed through unchecked.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single read: requester 1 reads addr 5 (holding 0xDEADBEEF) → req_ready[1] in the same cycle, rsp_valid=3'b010 one cycle later, rsp_rdata=0xDEADBEEF, bram_wen=0.
- Round-robin: all 3 valid continuously from reset → grants 0,1,2,0,1,2; with only 0 and 2 valid after a grant to 0 → next grant 2.
- Write/read: requester 0 writes 0x12345678 to addr 100 (bram_wen=1111), requester 2 reads 100 next cycle → rsp_valid[2]=1, data 0x12345678.
- Clear with contention:
  - Stimulus: clr_start while req_valid=3'b111, using DEPTH=16 in the bench.
  - Expected: no grants for 17 cycles, 16 writes of 0 at addresses 0..15.
  - Expected: clr_done pulses once, grants resume with rr_ptr unchanged, and reads of addresses 0..15 return 0.
- Reset mid-clear: rst asserted at clr_addr=7 → immediately bram_en=0 and clr_busy=0; clr_done never pulses; post-reset requester 0 is granted first.
- BRAM_ARB_FIXED_PRIO_EN defined, all valid → requester 0 granted every cycle; with 3'b110 → requester 1 granted every cycle.
